// File: rtl/text_console_ctrl.sv
// Tile RAM write controller: char stream in, cursor tracking, full-screen clear; 1-cycle registered write.
// Ready drops during CLEAR and on a pending clear request. Optional: CONSOLE_AUTOCLEAR_EN clears after reset.
module text_console_ctrl #(
    parameter int         COLS       = 80,
    parameter int         ROWS       = 30,
    parameter logic [6:0] SPACE_CHAR = 7'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [6:0]  char_data,
    output logic        char_ready,
    input  logic        clr_req,
    output logic        ram_we,
    output logic [11:0] ram_addr,
    output logic [6:0]  ram_din,
    output logic [6:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic        busy
);

    localparam logic [6:0] X_MAX = 7'(COLS - 1);
    localparam logic [4:0] Y_MAX = 5'(ROWS - 1);

    localparam logic [6:0] CODE_BS = 7'h08;
    localparam logic [6:0] CODE_LF = 7'h0A;
    localparam logic [6:0] CODE_CR = 7'h0D;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state;
    logic [6:0] cx;
    logic [4:0] cy;
    logic       start_pending;
    logic       take;
    logic       printable;
    logic       x_last;
    logic [4:0] y_inc;

`ifdef CONSOLE_AUTOCLEAR_EN
    // Set by reset, consumed by the first edge: forces an initial clear.
    logic first_cyc;
    assign start_pending = first_cyc;
`else
    assign start_pending = 1'b0;
`endif

    assign char_ready = (state == IDLE) & ~clr_req & ~start_pending;
    assign take       = char_valid & char_ready;
    assign printable  = (char_data >= 7'h20) && (char_data <= 7'h7E);
    assign x_last     = (cur_x == X_MAX);
    assign y_inc      = (cur_y == Y_MAX) ? 5'd0 : cur_y + 5'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ram_we   <= 1'b0;
            ram_addr <= 12'd0;
            ram_din  <= 7'd0;
            cur_x    <= 7'd0;
            cur_y    <= 5'd0;
            busy     <= 1'b0;
            cx       <= 7'd0;
            cy       <= 5'd0;
`ifdef CONSOLE_AUTOCLEAR_EN
            first_cyc <= 1'b1;
`endif
        end else begin
            ram_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_req || start_pending) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        cx    <= 7'd0;
                        cy    <= 5'd0;
`ifdef CONSOLE_AUTOCLEAR_EN
                        first_cyc <= 1'b0;
`endif
                    end else if (take) begin
                        if (printable) begin
                            ram_we   <= 1'b1;
                            ram_addr <= {cur_y, cur_x};
                            ram_din  <= char_data;
                            if (x_last) begin
                                cur_x <= 7'd0;
                                cur_y <= y_inc;
                            end else begin
                                cur_x <= cur_x + 7'd1;
                            end
                        end else if (char_data == CODE_CR) begin
                            cur_x <= 7'd0;
                        end else if (char_data == CODE_LF) begin
                            cur_y <= y_inc;
                        end else if (char_data == CODE_BS && cur_x != 7'd0) begin
                            // Erase lands on the cell the cursor moves back onto.
                            cur_x    <= cur_x - 7'd1;
                            ram_we   <= 1'b1;
                            ram_addr <= {cur_y, cur_x - 7'd1};
                            ram_din  <= SPACE_CHAR;
                        end
                    end
                end
                CLEAR: begin
                    ram_we   <= 1'b1;
                    ram_addr <= {cy, cx};
                    ram_din  <= SPACE_CHAR;
                    if (cx == X_MAX) begin
                        cx <= 7'd0;
                        if (cy == Y_MAX) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            cur_x <= 7'd0;
                            cur_y <= 5'd0;
                        end else begin
                            cy <= cy + 5'd1;
                        end
                    end else begin
                        cx <= cx + 7'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Self-checking bench for text_console_ctrl: randomized character streams against a cursor/screen model.
module tb_text_console_ctrl;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        char_valid;
    logic [6:0]  char_data;
    logic        char_ready;
    logic        clr_req;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [6:0]  ram_din;
    logic [6:0]  cur_x;
    logic [4:0]  cur_y;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cursor as plain integers, expected held write outputs, screen image.
    int          mx, my;
    logic        e_we;
    logic [11:0] e_addr;
    logic [6:0]  e_din;
    logic [6:0]  mram [4096] = '{default: 7'h0};
    logic [6:0]  dram [4096] = '{default: 7'h0};

    wire [31:0] obs = {ram_we, ram_addr, ram_din, cur_x, cur_y};

    text_console_ctrl dut (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char_data(char_data),
        .char_ready(char_ready), .clr_req(clr_req), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_din(ram_din), .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we === 1'b1) dram[ram_addr] <= ram_din;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] exp_vec();
        return {e_we, e_addr, e_din, 7'(mx), 5'(my)};
    endfunction

    function automatic logic [6:0] rnd_print();
        return 7'($urandom_range(32, 126));
    endfunction

    task automatic model_char(input logic [6:0] c);
        int p;
        e_we = 1'b0;
        if (c >= 7'h20 && c <= 7'h7E) begin
            e_we = 1'b1; e_addr = 12'(my * 128 + mx); e_din = c; mram[e_addr] = c;
            p  = (my * COLS + mx + 1) % (COLS * ROWS);
            mx = p % COLS;
            my = p / COLS;
        end else if (c == 7'h0D) begin
            mx = 0;
        end else if (c == 7'h0A) begin
            my = (my + 1) % ROWS;
        end else if (c == 7'h08 && mx > 0) begin
            mx = mx - 1;
            e_we = 1'b1; e_addr = 12'(my * 128 + mx); e_din = 7'h20; mram[e_addr] = 7'h20;
        end
    endtask

    task automatic model_clear();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) mram[y * 128 + x] = 7'h20;
        mx = 0; my = 0; e_we = 1'b0;
        e_addr = 12'((ROWS - 1) * 128 + COLS - 1); e_din = 7'h20;
    endtask

    task automatic model_reset();
        mx = 0; my = 0; e_we = 1'b0; e_addr = 12'd0; e_din = 7'd0;
    endtask

    // Drive one cycle of input from just after an edge; returns the ready seen before the next edge.
    task automatic step(input logic v, input logic [6:0] d, output logic rdy);
        char_valid = v; char_data = d;
        #1 rdy = char_ready;
        @(posedge clk); #1;
        if (v && rdy) model_char(d); else e_we = 1'b0;
    endtask

    // Watches a clear from the cycle after the entry edge; optionally pokes clr_req while busy.
    task automatic observe_clear(input bit poke, output int bc, output int wc, output int bad,
                                 output logic [11:0] first_a, output logic [11:0] last_a,
                                 output int rdy_busy);
        int k;
        bc = 0; wc = 0; bad = 0; rdy_busy = 0; k = 0; first_a = 'x; last_a = 'x;
        for (int i = 0; i < 2405; i++) begin
            clr_req = poke && (i >= 10) && (i < 2000) && ($urandom_range(0, 3) == 0);
            #1;
            if (busy === 1'b1) bc++;
            if (busy === 1'b1 && char_ready !== 1'b0) rdy_busy++;
            if (ram_we === 1'b1) begin
                if (ram_addr !== 12'((k / COLS) * 128 + k % COLS) || ram_din !== 7'h20) bad++;
                if (k == 0) first_a = ram_addr;
                last_a = ram_addr;
                k++; wc++;
            end
            clr_req = 1'b0;
            @(posedge clk); #1;
        end
    endtask

`ifdef CONSOLE_AUTOCLEAR_EN
    task automatic test_autoclear();
        int bc, wc, bad, rb;
        logic [11:0] fa, la;
        n_checks++;
        if (char_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL autoclear_first_cycle ready=%b busy=%b, want 0 0", char_ready, busy);
        end
        @(posedge clk); #1;
        observe_clear(1'b0, bc, wc, bad, fa, la, rb);
        model_clear();
        n_checks++;
        if (bc != 2400 || wc != 2400 || bad != 0 || rb != 0) begin
            n_fail++; $display("FAIL autoclear_run busy=%0d writes=%0d bad=%0d rdy_busy=%0d, want 2400 2400 0 0", bc, wc, bad, rb);
        end
        n_checks++;
        if (char_ready !== 1'b1 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL autoclear_end ready=%b out=%h, want 1 %h", char_ready, obs, exp_vec());
        end
    endtask
`else
    task automatic test_quiet_after_reset();
        int bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (ram_we !== 1'b0 || busy !== 1'b0 || char_ready !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL quiet_after_reset bad_cycles=%0d, want 0", bad); end
    endtask
`endif

    task automatic test_reset();
        reset = 1'b1; char_valid = 1'b0; char_data = 7'd0; clr_req = 1'b0;
        model_reset();
        #3;
        n_checks++;
        if ({obs, busy} !== 33'd0) begin
            n_fail++; $display("FAIL reset_outputs got %h busy=%b, want 0", obs, busy);
        end
        @(posedge clk); #1 reset = 1'b0; #1;
`ifdef CONSOLE_AUTOCLEAR_EN
        test_autoclear();
`else
        test_quiet_after_reset();
`endif
    endtask

    task automatic test_single_char();
        logic rdy;
        logic [31:0] want;
        want = {1'b1, 12'h000, 7'h41, 7'd1, 5'd0};
        step(1'b1, 7'h41, rdy);
        n_checks++;
        if (obs !== want || rdy !== 1'b1) begin
            n_fail++; $display("FAIL single_char got %h rdy=%b, want %h rdy=1", obs, rdy, want);
        end
        step(1'b0, 7'h00, rdy);
        n_checks++;
        if (ram_we !== 1'b0 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL single_char_drop got %h, want %h", obs, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        logic rdy;
        logic [31:0] want;
        int bad = 0;
        for (int i = 0; i < 2398; i++) begin
            step(1'b1, rnd_print(), rdy);
            if (obs !== exp_vec() || rdy !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL back_to_back bad_cycles=%0d, want 0", bad); end
        n_checks++;
        if (cur_x !== 7'd79 || cur_y !== 5'd29) begin
            n_fail++; $display("FAIL wrap_position got (%0d,%0d), want (79,29)", cur_x, cur_y);
        end
        want = {1'b1, 12'hECF, 7'h5A, 7'd0, 5'd0};
        step(1'b1, 7'h5A, rdy);
        char_valid = 1'b0;
        n_checks++;
        if (obs !== want) begin n_fail++; $display("FAIL wrap_last_cell got %h, want %h", obs, want); end
    endtask

    task automatic test_backspace();
        logic rdy;
        logic [31:0] want;
        int bad = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 7'h0A, rdy);
            if (obs !== exp_vec()) bad++;
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, rnd_print(), rdy);
            if (obs !== exp_vec()) bad++;
        end
        n_checks++;
        if (bad != 0 || cur_x !== 7'd5 || cur_y !== 5'd3) begin
            n_fail++; $display("FAIL bs_setup bad=%0d pos=(%0d,%0d), want 0 (5,3)", bad, cur_x, cur_y);
        end
        want = {1'b1, 12'h184, 7'h20, 7'd4, 5'd3};
        step(1'b1, 7'h08, rdy);
        n_checks++;
        if (obs !== want) begin n_fail++; $display("FAIL bs_erase got %h, want %h", obs, want); end
        want = {1'b0, 12'h184, 7'h20, 7'd0, 5'd3};
        step(1'b1, 7'h0D, rdy);
        n_checks++;
        if (obs !== want) begin n_fail++; $display("FAIL cr got %h, want %h", obs, want); end
        step(1'b1, 7'h08, rdy);
        char_valid = 1'b0;
        n_checks++;
        if (obs !== want) begin n_fail++; $display("FAIL bs_at_col0 got %h, want %h", obs, want); end
    endtask

    task automatic test_random(input int n);
        logic rdy, v;
        logic [6:0] c;
        int r, bad = 0, nrdy = 0;
        for (int i = 0; i < n; i++) begin
            v = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 9);
            if (r < 5)       c = rnd_print();
            else if (r == 5) c = 7'h0D;
            else if (r == 6) c = 7'h0A;
            else if (r < 9)  c = 7'h08;
            else begin
                c = 7'($urandom_range(0, 31));
                if (c == 7'h08 || c == 7'h0A || c == 7'h0D) c = 7'h7F;
            end
            step(v, c, rdy);
            if (v && rdy !== 1'b1) nrdy++;
            if (obs !== exp_vec()) begin
                bad++;
                if (bad < 4) $display("FAIL random_step %0d code=%h got %h, want %h", i, c, obs, exp_vec());
            end
        end
        char_valid = 1'b0;
        n_checks++;
        if (bad != 0 || nrdy != 0) begin
            n_fail++; $display("FAIL random_stream bad=%0d not_ready=%0d, want 0 0", bad, nrdy);
        end
    endtask

    task automatic test_clear();
        int bc, wc, bad, rb;
        logic [11:0] fa, la;
        clr_req = 1'b1; char_valid = 1'b1; char_data = 7'h51;
        #1;
        n_checks++;
        if (char_ready !== 1'b0) begin n_fail++; $display("FAIL clear_priority ready=%b, want 0", char_ready); end
        @(posedge clk); #1;
        clr_req = 1'b0; char_valid = 1'b0;
        observe_clear(1'b1, bc, wc, bad, fa, la, rb);
        model_clear();
        n_checks++;
        if (bc != 2400) begin n_fail++; $display("FAIL clear_busy_cycles got %0d, want 2400", bc); end
        n_checks++;
        if (wc != 2400 || bad != 0) begin n_fail++; $display("FAIL clear_writes got %0d bad=%0d, want 2400 0", wc, bad); end
        n_checks++;
        if (fa !== 12'h000 || la !== 12'hECF) begin
            n_fail++; $display("FAIL clear_span got %h..%h, want 000..ecf", fa, la);
        end
        n_checks++;
        if (rb != 0) begin n_fail++; $display("FAIL clear_ready_low got %0d ready cycles, want 0", rb); end
        n_checks++;
        if (char_ready !== 1'b1 || busy !== 1'b0 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL clear_end ready=%b busy=%b out=%h, want 1 0 %h", char_ready, busy, obs, exp_vec());
        end
    endtask

    task automatic test_reset_abort();
        int cnt = 0;
        clr_req = 1'b1;
        @(posedge clk); #1 clr_req = 1'b0;
        for (int i = 0; i < 300 && cnt < 100; i++) begin
            @(posedge clk); #1;
            if (ram_we === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt != 100) begin n_fail++; $display("FAIL abort_reach100 got %0d writes, want 100", cnt); end
        @(posedge clk); #1;
        for (int k = 0; k < 100; k++) mram[(k / COLS) * 128 + k % COLS] = 7'h20;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (ram_we !== 1'b0 || {obs, busy} !== 33'd0) begin
            n_fail++; $display("FAIL abort_reset got %h busy=%b, want 0", obs, busy);
        end
        model_reset();
        @(posedge clk); #1;
        n_checks++;
        if (ram_we !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_held we=%b busy=%b, want 0 0", ram_we, busy);
        end
        reset = 1'b0; #1;
`ifdef CONSOLE_AUTOCLEAR_EN
        test_autoclear();
`else
        test_quiet_after_reset();
`endif
    endtask

    task automatic test_ram_contents();
        int bad = 0;
        @(posedge clk); #1;
        for (int a = 0; a < 4096; a++) if (dram[a] !== mram[a]) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL ram_image %0d cells differ, want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_back_to_back();
        test_backspace();
        test_random(400);
        test_clear();
        test_random(300);
        test_reset_abort();
        test_random(200);
        test_ram_contents();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
Write-side controller for the 80x30 character tile RAM that sits in front of the video RAM write port.
- Accepts a 7-bit character stream over a valid/ready handshake.
- Interprets the control codes CR, LF and BS, and maintains the text cursor.
- Sequences a full-screen clear on request.
- Is the only driver of the tile RAM write port; its cursor outputs feed the cursor-highlight logic in the display path.

Parameters:
COLS, 80, columns per row; x range 0..COLS-1, 1 to 128.
ROWS, 30, rows per screen; y range 0..ROWS-1, 1 to 32.
SPACE_CHAR, 7'h20, fill code written by clear and by backspace.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
char_valid  in  1  char_data holds a character to consume
char_data  in  7  ASCII code
char_ready  out  1  controller can accept; transfer happens when char_valid & char_ready
clr_req  in  1  request full-screen clear, sampled only in IDLE
ram_we  out  1  tile RAM write enable, registered
ram_addr  out  12  tile RAM write address {y[4:0], x[6:0]}, registered
ram_din  out  7  tile RAM write data, registered
cur_x  out  7  cursor column, registered
cur_y  out  5  cursor row, registered
busy  out  1  high while in CLEAR

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; ram_we=0, ram_addr=0, ram_din=0, cur_x=0, cur_y=0, busy=0. Reset asserted mid-clear aborts the clear immediately; no further writes occur.
- States: IDLE, CLEAR.
- char_ready = (state==IDLE) & ~clr_req. This is combinational; clear has priority over a same-cycle character.
- IDLE, clr_req=1 at edge: go to CLEAR; clear counters set to (0,0); busy=1 from the next cycle.
- IDLE, transfer at edge N: the effect is visible after edge N. Any RAM write has ram_we=1 during cycle N+1 only. Throughput is one character per clock. ram_we=0 in any cycle without a write. ram_addr and ram_din hold their last value when not writing.
- Character handling:
  - 0x20..0x7E: write char at {cur_y,cur_x}, then advance.
  - 0x0D (CR): cur_x=0, no write.
  - 0x0A (LF): cur_y=(cur_y==ROWS-1)?0:cur_y+1; cur_x unchanged; no write.
  - 0x08 (BS): if cur_x>0, cur_x=cur_x-1 and write SPACE_CHAR at the new position. If cur_x==0, no change and no write.
  - All other codes: consumed, no effect.
- Advance rules:
  - If cur_x==COLS-1: cur_x=0 and cur_y=(cur_y==ROWS-1)?0:cur_y+1.
  - Otherwise cur_x+1.
  - No scrolling; the screen wraps to the top row.
- CLEAR: one write per clock of SPACE_CHAR at {cy,cx}.
  - cx counts 0..COLS-1; on wrap cy increments.
  - The write at (COLS-1, ROWS-1) is the last one: total COLS*ROWS writes (2400 at defaults), with ram_we continuously high.
  - The edge issuing the last write returns the controller to IDLE and sets cur_x=cur_y=0; busy=0 from the following cycle.
  - char_ready=0 and clr_req is ignored throughout CLEAR.
- Addresses with x>=COLS or y>=ROWS are never written.

Optional Feature:
CONSOLE_AUTOCLEAR_EN
- Defined: on the first clock edge after reset deasserts, the controller enters CLEAR as if clr_req were asserted. The screen is blanked to SPACE_CHAR before the first character is accepted; char_ready is 0 on that first cycle.
- Undefined: the controller starts in IDLE and RAM contents are untouched until a clear or character write.

Test Plan:
1. After reset, send 'A'(0x41): ram_we=1 for exactly one cycle with ram_addr=12'h000, ram_din=7'h41; then cur_x=1, cur_y=0.
2. Set the cursor to (79,29) by streaming characters, then send 'Z': write at {5'd29,7'd79}=12'hECF, then cursor=(0,0).
3. Cursor (5,3), send 0x08: write 0x20 at {3,4}=12'h184, cur_x=4. Then CR, then 0x08 again: cur_x=0, no write for that BS.
4. Assert clr_req and char_valid in the same cycle: char_ready=0. 2400 consecutive ram_we cycles with first addr 12'h000 and last 12'hECF, all din=0x20. busy=1 for 2400 cycles, then cursor=(0,0) and char_ready=1.
5. Assert reset after 100 clear writes: ram_we drops immediately and all outputs go to reset values. After release, no writes occur without stimulus (macro undefined).
6. With CONSOLE_AUTOCLEAR_EN defined, release reset: busy=1 from the second cycle, followed by 2400 clear writes before char_ready first goes high.
